// File: rtl/hhmm_display.sv
// hhmm_display: hour keeper and 4-digit multiplexed HH:MM display driver.
//
// Tracks the hour (0..23) and advances it whenever the upstream minute counter
// rolls over from 59 to 0. The hour can also be loaded directly. The minute
// and hour values are converted to registered BCD digits, which are then
// scanned onto a common 7-segment display, one digit at a time.
//
// Ports:
//   clk       - rising-edge clock
//   rst       - asynchronous active-high reset
//   min_cnt   - minute count 0..59 from upstream; values 60..63 are ignored
//   set_en    - one-cycle strobe that loads set_hour (values above 23 ignored)
//   set_hour  - hour value to load
//   hour      - current hour 0..23
//   hour_wrap - one-cycle pulse when the hour wraps from 23 to 0
//   min_tens, min_ones, hr_tens, hr_ones - registered BCD digits
//   seg       - active-low segments {g,f,e,d,c,b,a}
//   an        - active-low digit enables, an[0] is the rightmost digit
module hhmm_display #(
  parameter int SCAN_DIV = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] min_cnt,
  input  logic       set_en,
  input  logic [4:0] set_hour,
  output logic [4:0] hour,
  output logic       hour_wrap,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] hr_tens,
  output logic [3:0] hr_ones,
  output logic [6:0] seg,
  output logic [3:0] an
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  // Digit being scanned, in display order from right to left.
  typedef enum logic [1:0] {
    DIG_MIN_ONES = 2'd0,
    DIG_MIN_TENS = 2'd1,
    DIG_HR_ONES  = 2'd2,
    DIG_HR_TENS  = 2'd3
  } digit_t;

  logic [5:0]       min_q, min_d;
  logic [4:0]       hour_q, hour_d;
  logic             hour_wrap_q, hour_wrap_d;
  logic [3:0]       min_tens_q, min_tens_d;
  logic [3:0]       min_ones_q, min_ones_d;
  logic [3:0]       hr_tens_q, hr_tens_d;
  logic [3:0]       hr_ones_q, hr_ones_d;
  logic [DIV_W-1:0] div_q, div_d;
  digit_t           idx_q, idx_d;
  logic [6:0]       seg_q, seg_d;
  logic [3:0]       an_q, an_d;

  logic       min_valid;
  logic       set_valid;
  logic       rollover;
  logic [7:0] min_bcd;
  logic [7:0] hr_bcd;
  logic [3:0] sel_digit;
  logic       blank;

  // Binary (0..59) to two BCD digits by repeated subtraction of ten.
  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    logic [5:0] rem;
    logic [3:0] tens;
    rem  = v;
    tens = 4'd0;
    for (int i = 0; i < 5; i++) begin
      if (rem >= 6'd10) begin
        rem  = rem - 6'd10;
        tens = tens + 4'd1;
      end
    end
    return {tens, rem[3:0]};
  endfunction

  // Active-low gfedcba pattern; anything that is not a decimal digit is dark.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Minute capture and hour keeping. The rollover is seen as the registered
  // minute sitting at 59 while a valid 0 arrives, so out-of-range glitches in
  // between neither update min_q nor break the detection. A valid load wins
  // over a same-cycle rollover; an out-of-range load is treated as absent.
  always_comb begin
    min_valid   = (min_cnt <= 6'd59);
    set_valid   = set_en && (set_hour <= 5'd23);
    rollover    = (min_q == 6'd59) && min_valid && (min_cnt == 6'd0);
    min_d       = min_valid ? min_cnt : min_q;
    hour_d      = hour_q;
    hour_wrap_d = 1'b0;
    if (set_valid) begin
      hour_d = set_hour;
    end else if (rollover) begin
      if (hour_q == 5'd23) begin
        hour_d      = 5'd0;
        hour_wrap_d = 1'b1;
      end else begin
        hour_d = hour_q + 5'd1;
      end
    end
  end

  // BCD digits follow min_q and hour_q with one cycle of latency.
  always_comb begin
    min_bcd    = to_bcd(min_q);
    hr_bcd     = to_bcd({1'b0, hour_q});
    min_tens_d = min_bcd[7:4];
    min_ones_d = min_bcd[3:0];
    hr_tens_d  = hr_bcd[7:4];
    hr_ones_d  = hr_bcd[3:0];
  end

  // Scan timing: each digit is held for SCAN_DIV cycles, and the index steps
  // on the last cycle of each hold period.
  always_comb begin
    div_d = div_q + DIV_W'(1);
    idx_d = idx_q;
    if (div_q == DIV_LAST) begin
      div_d = '0;
      idx_d = digit_t'(idx_q + 2'd1);
    end
  end

  // Segment and anode selection from the current index; registered together
  // so they always change on the same edge. A zero hour-tens digit is blanked.
  always_comb begin
    an_d      = 4'b1110;
    sel_digit = min_ones_q;
    blank     = 1'b0;
    case (idx_q)
      DIG_MIN_ONES: begin
        an_d      = 4'b1110;
        sel_digit = min_ones_q;
      end
      DIG_MIN_TENS: begin
        an_d      = 4'b1101;
        sel_digit = min_tens_q;
      end
      DIG_HR_ONES: begin
        an_d      = 4'b1011;
        sel_digit = hr_ones_q;
      end
      DIG_HR_TENS: begin
        an_d      = 4'b0111;
        sel_digit = hr_tens_q;
        blank     = (hr_tens_q == 4'd0);
      end
      default: begin
        an_d      = 4'b1110;
        sel_digit = min_ones_q;
      end
    endcase
    seg_d = blank ? 7'b1111111 : seg_decode(sel_digit);
  end

  // State registers; reset leaves digit 0 lit showing "0".
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      min_q       <= 6'd0;
      hour_q      <= 5'd0;
      hour_wrap_q <= 1'b0;
      min_tens_q  <= 4'd0;
      min_ones_q  <= 4'd0;
      hr_tens_q   <= 4'd0;
      hr_ones_q   <= 4'd0;
      div_q       <= '0;
      idx_q       <= DIG_MIN_ONES;
      seg_q       <= 7'b1000000;
      an_q        <= 4'b1110;
    end else begin
      min_q       <= min_d;
      hour_q      <= hour_d;
      hour_wrap_q <= hour_wrap_d;
      min_tens_q  <= min_tens_d;
      min_ones_q  <= min_ones_d;
      hr_tens_q   <= hr_tens_d;
      hr_ones_q   <= hr_ones_d;
      div_q       <= div_d;
      idx_q       <= idx_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
    end
  end

  assign hour      = hour_q;
  assign hour_wrap = hour_wrap_q;
  assign min_tens  = min_tens_q;
  assign min_ones  = min_ones_q;
  assign hr_tens   = hr_tens_q;
  assign hr_ones   = hr_ones_q;
  assign seg       = seg_q;
  assign an        = an_q;

endmodule

// File: doc/hhmm_display.md
HHMM_DISPLAY -- requirements
Module: hhmm_display

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000, meaning clk cycles each display digit is held (minimum 2).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port min_cnt  input  6  minute count 0..59 from the upstream modulo-60 counter.
REQ-005 SHALL have port set_en  input  1  one-cycle strobe to load the hour.
REQ-006 SHALL have port set_hour  input  5  hour value to load, 0..23.
REQ-007 SHALL have port hour  output  5  current hour, 0..23.
REQ-008 SHALL have port hour_wrap  output  1  one-cycle pulse when hour wraps 23->0.
REQ-009 SHALL have port min_tens, min_ones, hr_tens, hr_ones  output  4 each  registered BCD digits.
REQ-010 SHALL have port seg  output  7  active-low segments {g,f,e,d,c,b,a}.
REQ-011 SHALL have port an  output  4  active-low digit enables; an[0] is the rightmost digit.

Function
REQ-012 SHALL register min_cnt into min_q every cycle when min_cnt<=59; values 60..63 SHALL leave min_q unchanged.
REQ-013 SHALL detect minute rollover when min_q==59 and valid min_cnt==0 in the same cycle; this is the only increment source.
REQ-014 On rollover: hour SHALL increment next edge; 23 wraps to 0 with hour_wrap=1 for exactly that one cycle; otherwise hour_wrap=0.
REQ-015 set_en with set_hour<=23 SHALL load hour next edge; set_hour>23 SHALL be ignored.
REQ-016 set_en SHALL take priority over a same-cycle rollover: hour=set_hour, no increment, hour_wrap=0.
REQ-017 BCD outputs SHALL be registered with one-cycle latency from min_q/hour: tens=value/10, ones=value%10.
REQ-018 Scan divider SHALL count 0..SCAN_DIV-1 then wrap to 0; the digit index (0..3) SHALL advance by one, wrapping 3->0, on each cycle the divider is at SCAN_DIV-1.
REQ-019 Digit mapping: index 0 = min_ones, an=1110; 1 = min_tens, an=1101; 2 = hr_ones, an=1011; 3 = hr_tens, an=0111.
REQ-020 seg and an SHALL be registered together, updated the cycle after the index changes; exactly one an bit low at all times.
REQ-021 seg codes (gfedcba): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-022 Index 3 with hr_tens==0 SHALL drive seg=1111111 (leading-zero blank); an SHALL still be 0111.
REQ-023 Any BCD value >9 on the selected digit SHALL drive seg=1111111.

Reset
REQ-024 On rst: min_q=0, hour=0, hour_wrap=0, all BCD outputs 0, divider=0, index=0, an=1110, seg=1000000.
REQ-025 rst asserted mid-scan or mid-rollover SHALL abort immediately; the first post-reset rollover requires min_q to reach 59 again.

Verification
REQ-026 Reset, min_cnt=0 -> an=1110, seg=1000000, hour=0; after SCAN_DIV cycles, index 1 -> an=1101 on the following edge.
REQ-027 min_cnt 58,59,0 on consecutive cycles with hour=5 -> hour=6 one cycle after the 0 arrives; hr_ones=6 one cycle later; hour_wrap stays 0.
REQ-028 hour=23 loaded via set_en, then 59->0 -> hour=0, single-cycle hour_wrap=1, hr_tens=0, digit 3 blanked (seg=1111111).
REQ-029 set_en=1, set_hour=12 on the rollover cycle -> hour=12, no increment; set_hour=25 -> hour unchanged.
REQ-030 min_cnt=62 injected between 59 and 0 -> min_q holds 59, rollover still fires on the 0, hour increments once.
REQ-031 hour=17, min_cnt=42 over a full 4*SCAN_DIV scan -> digit sequence 2,4,7,1 with codes 0100100, 0011001, 1111000, 1111001.
